// File: rtl/spi_master_regs_if.sv
// Register-bus bundle between the IPIF bridge (master) and the SPI master register block (slave).
interface spi_master_regs_if;
  logic [31:0]  bus2ip_data;
  logic [3:0]   bus2ip_wrce;
  logic [3:0]   bus2ip_rdce;
  logic [127:0] ip2bus_data;
  logic         ip2bus_wrack;
  logic         ip2bus_rdack;

  modport master (
    output bus2ip_data, bus2ip_wrce, bus2ip_rdce,
    input  ip2bus_data, ip2bus_wrack, ip2bus_rdack
  );

  modport slave (
    input  bus2ip_data, bus2ip_wrce, bus2ip_rdce,
    output ip2bus_data, ip2bus_wrack, ip2bus_rdack
  );
endinterface

// File: rtl/spi_master_regs.sv
// IPIF register block (CTRL/STATUS/TXDATA/RXDATA) driving a single-word SPI master.
// Supports all four CPOL/CPHA modes; a TXDATA write while idle launches a transfer.
module spi_master_regs #(
  parameter int DATA_W     = 8,
  parameter int CLKDIV_RST = 4
) (
  input  logic            bus2ip_clk,
  input  logic            bus2ip_reset,
  spi_master_regs_if.slave bus,
  output logic            SCLK,
  output logic            MOSI,
  input  logic            MISO,
  output logic            SS_n
);

  localparam logic [7:0] CLKDIV_RST_L = 8'(CLKDIV_RST);
  localparam logic [6:0] LAST_TOG     = 7'(2 * DATA_W - 1);

  typedef enum logic [1:0] {IDLE, LEAD, SHIFT, TRAIL} state_t;

  // Register file state
  logic              cpol_q, cpol_d;
  logic              cpha_q, cpha_d;
  logic [7:0]        clkdiv_q, clkdiv_d;
  logic              done_q, done_d;
  logic              ovr_q, ovr_d;
  logic              rxvalid_q, rxvalid_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [DATA_W-1:0] rx_q, rx_d;
  logic              wr_armed_q, wr_armed_d;
  logic              rd_armed_q, rd_armed_d;
  logic              wrack_q, wrack_d;
  logic              rdack_q, rdack_d;

  // Transfer engine state
  state_t            state_q;
  logic [7:0]        cnt_q;
  logic [6:0]        tog_q;
  logic              sclk_q;
  logic              mosi_q;
  logic              ss_n_q;
  logic [DATA_W-1:0] shift_q;

  logic [3:0]  wr_sel;
  logic [3:0]  rd_sel;
  logic        wr_acc;
  logic        rd_acc;
  logic        busy;
  logic        start;
  logic        xfer_done;
  logic        sample_edge;
  logic        unused_data;

  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] v, input logic b);
    logic [DATA_W:0] t;
    t = {v, b};
    return t[DATA_W-1:0];
  endfunction

  // Lowest set chip-enable bit wins when the bridge presents a non-one-hot pattern.
  assign wr_sel    = bus.bus2ip_wrce & (~bus.bus2ip_wrce + 4'd1);
  assign rd_sel    = bus.bus2ip_rdce & (~bus.bus2ip_rdce + 4'd1);
  assign wr_acc    = (bus.bus2ip_wrce != 4'b0) && wr_armed_q;
  assign rd_acc    = (bus.bus2ip_rdce != 4'b0) && rd_armed_q;
  assign busy      = (state_q != IDLE);
  assign start     = wr_acc && wr_sel[2] && !busy;
  assign xfer_done = (state_q == TRAIL) && (cnt_q == 8'd0);
  // CPHA=0 samples on leading toggles (even count), CPHA=1 on trailing (odd count).
  assign sample_edge = (tog_q[0] == cpha_q);
  assign unused_data = ^bus.bus2ip_data;

  assign bus.ip2bus_data[31:0]   = {16'b0, clkdiv_q, 6'b0, cpha_q, cpol_q};
  assign bus.ip2bus_data[63:32]  = {28'b0, rxvalid_q, ovr_q, done_q, busy};
  assign bus.ip2bus_data[95:64]  = 32'(tx_q);
  assign bus.ip2bus_data[127:96] = 32'(rx_q);
  assign bus.ip2bus_wrack        = wrack_q;
  assign bus.ip2bus_rdack        = rdack_q;

  assign SCLK = sclk_q;
  assign MOSI = mosi_q;
  assign SS_n = ss_n_q;

  always_comb begin
    cpol_d     = cpol_q;
    cpha_d     = cpha_q;
    clkdiv_d   = clkdiv_q;
    done_d     = done_q;
    ovr_d      = ovr_q;
    rxvalid_d  = rxvalid_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    wrack_d    = wr_acc;
    rdack_d    = rd_acc;
    wr_armed_d = wr_armed_q;
    rd_armed_d = rd_armed_q;

    // An accepted strobe disarms until the bridge drops its chip-enable.
    if (wr_acc)                         wr_armed_d = 1'b0;
    else if (bus.bus2ip_wrce == 4'b0)   wr_armed_d = 1'b1;
    if (rd_acc)                         rd_armed_d = 1'b0;
    else if (bus.bus2ip_rdce == 4'b0)   rd_armed_d = 1'b1;

    if (wr_acc) begin
      if (wr_sel[0] && !busy) begin
        cpol_d   = bus.bus2ip_data[0];
        cpha_d   = bus.bus2ip_data[1];
        clkdiv_d = bus.bus2ip_data[15:8];
      end
      if (wr_sel[1]) begin
        done_d = done_q & ~bus.bus2ip_data[1];
        ovr_d  = ovr_q  & ~bus.bus2ip_data[2];
      end
      if (wr_sel[2] && !busy) begin
        tx_d   = bus.bus2ip_data[DATA_W-1:0];
        done_d = 1'b0;
      end
    end

    if (rd_acc && rd_sel[3]) rxvalid_d = 1'b0;

    // Completion overrides same-edge clears; a coincident RXDATA read counts as consumed.
    if (xfer_done) begin
      done_d    = 1'b1;
      rx_d      = shift_q;
      rxvalid_d = 1'b1;
      if (rxvalid_q && !(rd_acc && rd_sel[3])) ovr_d = 1'b1;
    end
  end

  always_ff @(posedge bus2ip_clk or posedge bus2ip_reset) begin
    if (bus2ip_reset) begin
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      clkdiv_q   <= CLKDIV_RST_L;
      done_q     <= 1'b0;
      ovr_q      <= 1'b0;
      rxvalid_q  <= 1'b0;
      tx_q       <= '0;
      rx_q       <= '0;
      wrack_q    <= 1'b0;
      rdack_q    <= 1'b0;
      wr_armed_q <= 1'b1;
      rd_armed_q <= 1'b1;
    end else begin
      cpol_q     <= cpol_d;
      cpha_q     <= cpha_d;
      clkdiv_q   <= clkdiv_d;
      done_q     <= done_d;
      ovr_q      <= ovr_d;
      rxvalid_q  <= rxvalid_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      wrack_q    <= wrack_d;
      rdack_q    <= rdack_d;
      wr_armed_q <= wr_armed_d;
      rd_armed_q <= rd_armed_d;
    end
  end

  // Transfer FSM: every phase is CLKDIV+1 clocks, timed by a reload-on-zero down-counter.
  always_ff @(posedge bus2ip_clk or posedge bus2ip_reset) begin
    if (bus2ip_reset) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      tog_q   <= 7'd0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      ss_n_q  <= 1'b1;
      shift_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= LEAD;
            cnt_q   <= clkdiv_q;
            tog_q   <= 7'd0;
            sclk_q  <= cpol_q;
            ss_n_q  <= 1'b0;
            shift_q <= bus.bus2ip_data[DATA_W-1:0];
            if (!cpha_q) mosi_q <= bus.bus2ip_data[DATA_W-1];
          end
        end
        LEAD: begin
          if (cnt_q == 8'd0) begin
            state_q <= SHIFT;
            cnt_q   <= clkdiv_q;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        SHIFT: begin
          if (cnt_q == 8'd0) begin
            cnt_q  <= clkdiv_q;
            sclk_q <= ~sclk_q;
            tog_q  <= tog_q + 7'd1;
            if (sample_edge)              shift_q <= shift_in(shift_q, MISO);
            else if (tog_q != LAST_TOG)   mosi_q  <= shift_q[DATA_W-1];
            if (tog_q == LAST_TOG)        state_q <= TRAIL;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        TRAIL: begin
          if (cnt_q == 8'd0) begin
            state_q <= IDLE;
            ss_n_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_regs.sv
// Directed bench for spi_master_regs: bus reads are scored through an expectation queue,
// SPI pin activity is summarised per transfer by a pin monitor.
module tb_spi_master_regs;

  logic clk;
  logic rst;
  logic sclk_w, mosi_w, ss_n_w, miso_w;
  logic loop_en;
  logic miso_val;

  spi_master_regs_if bus_if();

  spi_master_regs #(.DATA_W(8), .CLKDIV_RST(4)) dut (
    .bus2ip_clk   (clk),
    .bus2ip_reset (rst),
    .bus          (bus_if),
    .SCLK         (sclk_w),
    .MOSI         (mosi_w),
    .MISO         (miso_w),
    .SS_n         (ss_n_w)
  );

  assign miso_w = loop_en ? mosi_w : miso_val;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [1:0]  idx;
    logic [31:0] val;
  } rd_exp_t;

  rd_exp_t exp_q[$];
  int checks   = 0;
  int failures = 0;
  int wrack_cnt = 0;
  int rdack_cnt = 0;

  // Per-transfer pin statistics
  bit   in_xfer = 0;
  bit   first_tog;
  logic prev_sclk;
  int   low_cnt, last_len, toggles, rises, since, gmin, gmax;
  logic [7:0] bits;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout expected=response", name);
  endtask

  // Read scoreboard monitor
  initial begin
    rd_exp_t e;
    forever begin
      @(negedge clk);
      if (bus_if.ip2bus_wrack) wrack_cnt++;
      if (bus_if.ip2bus_rdack) begin
        rdack_cnt++;
        if (exp_q.size() == 0) begin
          timeout_fail("rd_unexpected");
        end else begin
          e = exp_q.pop_front();
          check($sformatf("rd_reg%0d", e.idx), bus_if.ip2bus_data[e.idx*32 +: 32], e.val);
        end
      end
    end
  end

  // SPI pin monitor
  initial begin
    forever begin
      @(negedge clk);
      if (!ss_n_w) begin
        if (!in_xfer) begin
          in_xfer = 1; low_cnt = 0; toggles = 0; rises = 0; since = 0;
          gmin = 9999; gmax = 0; bits = 8'h00; first_tog = 1;
        end else begin
          since++;
          if (sclk_w != prev_sclk) begin
            toggles++;
            if (!first_tog) begin
              if (since < gmin) gmin = since;
              if (since > gmax) gmax = since;
            end
            first_tog = 0;
            since = 0;
            if (sclk_w) begin
              rises++;
              bits = {bits[6:0], mosi_w};
            end
          end
        end
        low_cnt++;
      end else if (in_xfer) begin
        in_xfer  = 0;
        last_len = low_cnt;
      end
      prev_sclk = sclk_w;
    end
  end

  task automatic do_write(input int idx, input logic [31:0] data);
    bit got;
    got = 0;
    @(posedge clk); #1;
    bus_if.bus2ip_data = data;
    bus_if.bus2ip_wrce = 4'(1 << idx);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus_if.ip2bus_wrack) begin got = 1; break; end
    end
    bus_if.bus2ip_wrce = 4'b0;
    if (!got) timeout_fail("wrack_wait");
  endtask

  task automatic do_read(input int idx, input logic [31:0] exp);
    rd_exp_t e;
    bit got;
    got = 0;
    e.idx = 2'(idx);
    e.val = exp;
    exp_q.push_back(e);
    @(posedge clk); #1;
    bus_if.bus2ip_rdce = 4'(1 << idx);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus_if.ip2bus_rdack) begin got = 1; break; end
    end
    bus_if.bus2ip_rdce = 4'b0;
    if (!got) timeout_fail("rdack_wait");
  endtask

  task automatic wait_idle();
    bit got;
    got = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (!bus_if.ip2bus_data[32] && ss_n_w) begin got = 1; break; end
    end
    @(negedge clk);
    if (!got) timeout_fail("idle_wait");
  endtask

  initial begin
    int wr_before;
    rst = 1'b1;
    loop_en = 1'b0;
    miso_val = 1'b0;
    bus_if.bus2ip_data = 32'h0;
    bus_if.bus2ip_wrce = 4'b0;
    bus_if.bus2ip_rdce = 4'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // 1: reset state
    check("rst_ss_n", 32'(ss_n_w), 32'h1);
    check("rst_sclk", 32'(sclk_w), 32'h0);
    check("rst_mosi", 32'(mosi_w), 32'h0);
    do_read(0, 32'h0000_0400);
    do_read(1, 32'h0000_0000);
    do_read(2, 32'h0000_0000);
    do_read(3, 32'h0000_0000);
    @(negedge clk);
    check("rst_rdack_count", 32'(rdack_cnt), 32'd4);
    check("rst_wrack_count", 32'(wrack_cnt), 32'd0);

    // 2: mode 0 loopback of 0xA5
    do_write(0, 32'h0000_0000);
    loop_en = 1'b1;
    do_write(2, 32'h0000_00A5);
    wait_idle();
    check("t2_ss_low", 32'(last_len), 32'd18);
    check("t2_sclk_rises", 32'(rises), 32'd8);
    check("t2_sclk_toggles", 32'(toggles), 32'd16);
    check("t2_mosi_bits", 32'(bits), 32'h0000_00A5);
    do_read(1, 32'h0000_000A);
    do_read(3, 32'h0000_00A5);
    do_read(1, 32'h0000_0002);

    // 3: lingering wrce writes once; TXDATA write while busy ignored
    loop_en = 1'b0;
    miso_val = 1'b0;
    wr_before = wrack_cnt;
    @(posedge clk); #1;
    bus_if.bus2ip_data = 32'h0000_003C;
    bus_if.bus2ip_wrce = 4'b0100;
    repeat (3) @(posedge clk);
    @(negedge clk);
    bus_if.bus2ip_wrce = 4'b0;
    check("t3_single_wrack", 32'(wrack_cnt - wr_before), 32'd1);
    do_write(2, 32'h0000_0055);
    do_read(1, 32'h0000_0001);
    do_read(2, 32'h0000_003C);
    wait_idle();
    check("t3_wrack_total", 32'(wrack_cnt - wr_before), 32'd2);
    check("t3_one_transfer", 32'(last_len), 32'd18);
    do_read(1, 32'h0000_000A);
    do_read(3, 32'h0000_0000);
    do_read(1, 32'h0000_0002);

    // 4: CPOL=1 CPHA=1, H=4, MISO tied high
    do_write(0, 32'h0000_0303);
    do_read(0, 32'h0000_0303);
    miso_val = 1'b1;
    do_write(2, 32'h0000_0000);
    check("t4_sclk_lead", 32'(sclk_w), 32'h1);
    check("t4_ss_low_lead", 32'(ss_n_w), 32'h0);
    wait_idle();
    check("t4_ss_low", 32'(last_len), 32'd72);
    check("t4_toggles", 32'(toggles), 32'd16);
    check("t4_gap_min", 32'(gmin), 32'd4);
    check("t4_gap_max", 32'(gmax), 32'd4);
    check("t4_sclk_idle", 32'(sclk_w), 32'h1);
    do_read(1, 32'h0000_000A);
    do_read(3, 32'h0000_00FF);

    // 5: overrun from two unread transfers, then W1C; CTRL write while busy ignored
    do_write(0, 32'h0000_0000);
    loop_en = 1'b1;
    do_write(2, 32'h0000_005A);
    wait_idle();
    do_read(1, 32'h0000_000A);
    do_write(2, 32'h0000_00C3);
    do_write(0, 32'h0000_FF03);
    wait_idle();
    do_read(0, 32'h0000_0000);
    do_read(1, 32'h0000_000E);
    do_write(1, 32'h0000_0006);
    do_read(1, 32'h0000_0008);
    do_read(3, 32'h0000_00C3);
    do_read(1, 32'h0000_0000);

    // 6: asynchronous reset mid-SHIFT
    loop_en = 1'b0;
    do_write(2, 32'h0000_00FF);
    repeat (5) @(negedge clk);
    #2;
    check("t6_ss_before", 32'(ss_n_w), 32'h0);
    rst = 1'b1;
    #1;
    check("t6_ss_async", 32'(ss_n_w), 32'h1);
    check("t6_sclk_async", 32'(sclk_w), 32'h0);
    check("t6_busy_async", 32'(bus_if.ip2bus_data[32]), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    do_read(1, 32'h0000_0000);
    do_read(0, 32'h0000_0400);
    do_read(3, 32'h0000_0000);

    repeat (4) @(negedge clk);
    check("rd_queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_master_regs.md
Name: spi_master_regs

Overview:
- Downstream IP stage behind the AXI-Lite-to-IPIF bridge.
- Consumes bus2ip_wrce/rdce/data and returns ip2bus_data plus one-cycle rdack/wrack pulses.
- Holds four 32-bit registers: CTRL, STATUS, TXDATA, RXDATA.
- Runs a single-word SPI master transfer, all four CPOL/CPHA modes, started by a TXDATA write.

Parameters:
DATA_W, 8, transfer word length in bits (legal 1..32)
CLKDIV_RST, 4, reset value of CTRL.CLKDIV

Ports:
bus2ip_clk  in  1  single clock; all logic on its rising edge
bus2ip_reset  in  1  asynchronous, active-high reset
bus2ip_data  in  32  write data
bus2ip_wrce  in  4  write chip-enable, one-hot per register (bit0=CTRL .. bit3=RXDATA)
bus2ip_rdce  in  4  read chip-enable, same mapping
ip2bus_data  out  128  [31:0]=CTRL, [63:32]=STATUS, [95:64]=TXDATA, [127:96]=RXDATA, driven continuously
ip2bus_wrack  out  1  write acknowledge pulse
ip2bus_rdack  out  1  read acknowledge pulse
SCLK  out  1  SPI clock
MOSI  out  1  SPI data out
MISO  in  1  SPI data in
SS_n  out  1  active-low slave select

Behaviour:
- Reset (async, immediate): SCLK=0, MOSI=0, SS_n=1, wrack=rdack=0, CTRL={16'b0,CLKDIV_RST[7:0],6'b0,CPHA=0,CPOL=0}, STATUS=TXDATA=RXDATA=0, FSM=IDLE.
- Reset during a transfer aborts it. SS_n rises asynchronously.
- Register fields:
  - CTRL: bit0 CPOL, bit1 CPHA, bits[15:8] CLKDIV; other bits read 0.
  - STATUS: bit0 BUSY (RO), bit1 DONE (W1C), bit2 OVERRUN (W1C), bit3 RXVALID (RO).
  - TXDATA: bits[DATA_W-1:0] stored; other bits read 0.
  - RXDATA: received word, zero-extended; writes are ignored.
- Handshake:
  - Write accept edge: wrce!=0 AND wr_armed. At that edge the register updates and wrack goes 1 for exactly one cycle; wr_armed clears.
  - wr_armed sets again only on an edge where wrce==0. This stops the bridge's lingering wrce (held until it sees wrack) from writing twice.
  - Reads use the same scheme with rdce, rd_armed and rdack. Data is already valid on ip2bus_data when rdack is high.
  - wrce and rdce are handled independently and may be accepted on the same edge.
  - Non-one-hot ce: the lowest set bit wins.
- Write side effects:
  - CTRL write while BUSY is ignored; wrack is still given.
  - STATUS write clears DONE/OVERRUN where data bit is 1.
  - TXDATA write while idle stores the word, clears DONE and starts a transfer on the same edge. While BUSY it is ignored (wrack given).
- Read side effects: an accepted RXDATA read clears RXVALID. Other reads have no side effects.
- FSM: IDLE -> LEAD -> SHIFT -> TRAIL -> IDLE.
  - Half-period H = CLKDIV+1 clocks, counted by a down-counter.
  - IDLE -> LEAD on TXDATA accept: SS_n=0, BUSY=1, SCLK=CPOL. If CPHA=0, MOSI=first bit.
  - LEAD lasts H clocks, then SHIFT.
  - SHIFT: SCLK toggles every H clocks for 2*DATA_W toggles, MSB first.
    - CPHA=0: sample MISO on leading edges; drive next MOSI bit on trailing edges (none after the last).
    - CPHA=1: drive MOSI on leading edges; sample on trailing edges.
  - TRAIL: SCLK=CPOL, held H clocks.
  - TRAIL -> IDLE: SS_n=1, BUSY=0, DONE=1, RXDATA=shift register, RXVALID=1. If RXVALID was already 1, OVERRUN=1.
- SS_n low time = (2*DATA_W+2)*H clocks; DATA_W=8, CLKDIV=0 gives 18.
- MISO is sampled into the shift register on the bus clock edge that toggles SCLK to the sampling level.
- Completion and RXDATA read accepted on the same edge: the new word loads, RXVALID stays 1, OVERRUN is not set.
- CLKDIV=255 gives H=256; the counter must not wrap incorrectly.

Test Plan:
1. Reset then read all four registers -> CTRL=0x00000400 (CLKDIV_RST=4), STATUS=TXDATA=RXDATA=0, SS_n=1, SCLK=0, one rdack per read.
2. Write CTRL=0x00000000, then TXDATA=0xA5 with MISO looping back MOSI -> 8 SCLK pulses, MOSI serialises 1,0,1,0,0,1,0,1; SS_n low 18 clocks; then STATUS=0x0000000A, RXDATA=0x000000A5.
3. Hold wrce=4'b0100 for 3 cycles with data 0x3C -> exactly one wrack and one transfer; a second TXDATA write while BUSY=1 leaves TXDATA=0x3C.
4. CTRL=0x00000303 (CPOL=1, CPHA=1, H=4) with MISO tied 1 and TXDATA=0x00 -> SCLK idles 1, toggles every 4 clocks; RXDATA=0xFF.
5. Two transfers with no RXDATA read between -> STATUS bit2 (OVERRUN)=1; write STATUS=0x6 -> bits1,2 clear, RXVALID=1 remains.
6. Assert bus2ip_reset mid-SHIFT -> SS_n=1 and SCLK=0 immediately (before the next clock edge); BUSY=0 after release.
